// File: rtl/pd_block_debug_pkg.sv
// pd_block_debug_pkg: shared debug-path types and jdo field positions.
package pd_block_debug_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} mem_bridge_state_t;
  localparam int JDO_RD_BIT      = 35;
  localparam int JDO_AUTOINC_BIT = 34;
  localparam int JDO_ADDR_MSB    = 31;
  localparam int JDO_ADDR_LSB    = 2;
  localparam int MON_AW          = 30;
endpackage

// File: rtl/pd_block_nios2e_cpu_debug_mem_bridge.sv
// pd_block_nios2e_cpu_debug_mem_bridge: turns debug ocimem commands into single-word Avalon-MM accesses.
module pd_block_nios2e_cpu_debug_mem_bridge
  import pd_block_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);
  mem_bridge_state_t state;
  logic [MON_AW-1:0] mon_a_reg;
  logic autoinc;
  logic [CW-1:0] cnt;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[33:32]};
  assign avm_address = {mon_a_reg, 2'b00};
  assign avm_byteenable = 4'hF;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      mon_a_reg <= '0;
      autoinc <= 1'b0;
      cnt <= '0;
      MonDReg <= '0;
      avm_writedata <= '0;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (take_action_ocimem_a) begin
        mon_a_reg <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
        autoinc <= jdo[JDO_AUTOINC_BIT];
        monitor_error <= 1'b0;
        if (jdo[JDO_RD_BIT]) begin
          monitor_ready <= 1'b0;
          avm_read <= 1'b1;
          state <= RD;
        end
      end else if (take_action_ocimem_b) begin
        MonDReg <= jdo[31:0];
        avm_writedata <= jdo[31:0];
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
        avm_write <= 1'b1;
        state <= WR;
      end else if (take_no_action_ocimem_a && autoinc) begin
        monitor_ready <= 1'b0;
        avm_read <= 1'b1;
        state <= RD;
      end
    end else if (!avm_waitrequest) begin
      if (state == RD) MonDReg <= avm_readdata;
      if (autoinc) mon_a_reg <= mon_a_reg + 30'd1;
      monitor_ready <= 1'b1;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      state <= IDLE;
    end else if (cnt == T_MAX) begin
      // abort: address and read data are left as they were
      monitor_ready <= 1'b1;
      monitor_error <= 1'b1;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      state <= IDLE;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_pd_block_nios2e_cpu_debug_mem_bridge.sv
// tb_pd_block_nios2e_cpu_debug_mem_bridge: directed plus randomized checks against a transaction-level model.
module tb_pd_block_nios2e_cpu_debug_mem_bridge;
  localparam int T = 7;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic a = 1'b0, b = 1'b0, na = 1'b0;
  logic [31:0] avm_address, avm_writedata, avm_readdata = '0, MonDReg;
  logic avm_read, avm_write, avm_waitrequest = 1'b0, monitor_ready, monitor_error;
  logic [3:0] avm_byteenable;
  int vectors = 0, miscompares = 0;
  logic [29:0] m_addr = '0;
  logic m_auto = 1'b0, m_ready = 1'b0, m_err = 1'b0;
  logic [31:0] m_dreg = '0, m_wdata = '0;

  pd_block_nios2e_cpu_debug_mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(a), .take_action_ocimem_b(b), .take_no_action_ocimem_a(na),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ":read"}, 32'(avm_read), 32'd0);
    chk({tag, ":write"}, 32'(avm_write), 32'd0);
    chk({tag, ":ready"}, 32'(monitor_ready), 32'(m_ready));
    chk({tag, ":error"}, 32'(monitor_error), 32'(m_err));
    chk({tag, ":mondreg"}, MonDReg, m_dreg);
    chk({tag, ":addr"}, avm_address, {m_addr, 2'b00});
    chk({tag, ":wdata"}, avm_writedata, m_wdata);
    chk({tag, ":byteen"}, 32'(avm_byteenable), 32'hF);
  endtask

  task automatic cmd_a(input logic rd, input logic au, input logic [31:0] addr);
    jdo = {2'($urandom), rd, au, 2'($urandom), addr};
    a = 1'b1;
    tick;
    a = 1'b0;
    m_addr = addr[31:2];
    m_auto = au;
    m_err = 1'b0;
    if (rd) m_ready = 1'b0;
  endtask

  task automatic cmd_b(input logic [31:0] d);
    jdo = {6'($urandom), d};
    b = 1'b1;
    tick;
    b = 1'b0;
    m_dreg = d;
    m_wdata = d;
    m_ready = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic cmd_na;
    na = 1'b1;
    tick;
    na = 1'b0;
    if (m_auto) m_ready = 1'b0;
  endtask

  // Drives one access to completion: waits stalled cycles, then accept (or abort past T).
  task automatic run(input logic rd, input int waits, input logic [31:0] rdata, input logic mid_strobe);
    int n;
    n = (waits <= T) ? waits + 1 : T + 1;
    for (int i = 0; i < n; i++) begin
      avm_waitrequest = (i < waits);
      avm_readdata = (i < waits) ? $urandom : rdata;
      chk("req:read", 32'(avm_read), 32'(rd));
      chk("req:write", 32'(avm_write), 32'(!rd));
      chk("req:addr", avm_address, {m_addr, 2'b00});
      chk("req:ready", 32'(monitor_ready), 32'd0);
      if (!rd) chk("req:wdata", avm_writedata, m_wdata);
      if (mid_strobe && i == 1) begin
        jdo = {2'b11, 4'hF, $urandom};
        a = 1'b1;
        b = 1'b1;
        na = 1'b1;
      end
      tick;
      a = 1'b0;
      b = 1'b0;
      na = 1'b0;
    end
    avm_waitrequest = 1'b0;
    avm_readdata = $urandom;
    if (waits <= T) begin
      if (rd) m_dreg = rdata;
      if (m_auto) m_addr = m_addr + 30'd1;
    end else begin
      m_err = 1'b1;
    end
    m_ready = 1'b1;
    chk_idle("done");
  endtask

  initial begin
    logic [31:0] d;
    int kind, w;
    repeat (3) tick;
    chk_idle("reset");
    reset_n = 1'b1;
    tick;
    chk_idle("post_reset");

    cmd_a(1'b1, 1'b0, 32'h0000_1000);
    run(1'b1, 0, 32'hDEADBEEF, 1'b0);

    cmd_a(1'b0, 1'b0, 32'h0000_0020);
    chk_idle("addr_only");
    cmd_b(32'h1234_5678);
    run(1'b0, 3, 32'h0, 1'b0);

    cmd_a(1'b1, 1'b1, 32'h0000_0100);
    run(1'b1, 0, $urandom, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cmd_na;
      run(1'b1, k, $urandom, 1'b0);
    end
    chk("stream_end_addr", avm_address, 32'h0000_0110);

    cmd_a(1'b1, 1'b1, 32'h0000_0200);
    run(1'b1, 40, 32'h0BAD_0BAD, 1'b0);
    cmd_a(1'b0, 1'b0, 32'h0000_0300);
    chk_idle("err_clear");

    cmd_a(1'b1, 1'b1, 32'hFFFF_FFFC);
    run(1'b1, 1, $urandom, 1'b0);
    chk("wrap_addr", avm_address, 32'h0);

    jdo = {2'b00, 1'b1, 1'b0, 2'b00, 32'h0000_0440};
    a = 1'b1;
    b = 1'b1;
    na = 1'b1;
    tick;
    a = 1'b0;
    b = 1'b0;
    na = 1'b0;
    m_addr = 30'h110;
    m_auto = 1'b0;
    m_ready = 1'b0;
    m_err = 1'b0;
    run(1'b1, 2, 32'hCAFE_F00D, 1'b0);

    cmd_a(1'b1, 1'b1, 32'h0000_0800);
    run(1'b1, 3, 32'h5555_AAAA, 1'b1);
    cmd_b(32'hA5A5_5A5A);
    run(1'b0, 2, 32'h0, 1'b1);

    cmd_a(1'b0, 1'b0, 32'h0000_0900);
    cmd_na;
    chk_idle("na_ignored");

    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 2);
      w = $urandom_range(0, 9);
      d = $urandom;
      if (kind == 0) begin
        cmd_a(1'b1, 1'($urandom), $urandom);
        run(1'b1, w, d, 1'b0);
      end else if (kind == 1) begin
        cmd_a(1'b0, 1'($urandom), $urandom);
        cmd_b(d);
        run(1'b0, w, 32'h0, 1'b0);
      end else begin
        cmd_na;
        if (m_auto) run(1'b1, w, d, 1'b0);
        else chk_idle("rand_na_ignored");
      end
    end

    cmd_a(1'b1, 1'b1, 32'h0000_1230);
    avm_waitrequest = 1'b1;
    tick;
    tick;
    reset_n = 1'b0;
    tick;
    m_addr = '0;
    m_auto = 1'b0;
    m_ready = 1'b0;
    m_err = 1'b0;
    m_dreg = '0;
    m_wdata = '0;
    chk_idle("mid_reset");
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    tick;
    chk_idle("after_mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pd_block_nios2e_cpu_debug_mem_bridge.md
# pd_block_nios2e_cpu_debug_mem_bridge

Downstream consumer of the debug-slave sysclk stage: turns the `jdo` payload and `take_action_ocimem_*` strobes into single-word Avalon-MM reads and writes on the system bus. It returns read data and status to the debug TCK domain through `MonDReg`, `monitor_ready` and `monitor_error`. It sits between the debug slave wrapper and the system interconnect, on the CPU clock.

## Interface
- `TIMEOUT_CYCLES`, default 1023: maximum number of cycles an access may stall on `avm_waitrequest` before it is aborted.
- `clk`  in  1: system clock; all logic on its rising edge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `jdo`  in  38: debug command payload from the sysclk stage.
- `take_action_ocimem_a`  in  1: one-cycle strobe; address/read command.
- `take_action_ocimem_b`  in  1: one-cycle strobe; write command.
- `take_no_action_ocimem_a`  in  1: one-cycle strobe; streaming read at current address.
- `avm_address`  out  32: byte address, `{MonAReg, 2'b00}`.
- `avm_read`  out  1: read request.
- `avm_write`  out  1: write request.
- `avm_writedata`  out  32: write data.
- `avm_byteenable`  out  4: constant 4'hF.
- `avm_readdata`  in  32: read data, valid when `avm_read` is high and `avm_waitrequest` is low.
- `avm_waitrequest`  in  1: slave stall.
- `MonDReg`  out  32: last read data, or the data of the last write command.
- `monitor_ready`  out  1: the last access completed or aborted.
- `monitor_error`  out  1: the last access timed out.

## Operation
- State machine states: IDLE, RD, WR.
- Internal registers: `MonAReg[29:0]` (word address), `autoinc`, and a timeout counter of width clog2(TIMEOUT_CYCLES+1).
- In IDLE, `take_action_ocimem_a`:
  - Loads `MonAReg <= jdo[31:2]` and `autoinc <= jdo[34]`.
  - Clears `monitor_error`.
  - If `jdo[35]`=1, clears `monitor_ready` and goes to RD.
  - If `jdo[35]`=0, loads the address only and leaves `monitor_ready` unchanged.
- In IDLE, `take_action_ocimem_b`: `MonDReg <= jdo[31:0]`, `avm_writedata <= jdo[31:0]`, clears `monitor_ready` and `monitor_error`, goes to WR.
- In IDLE, `take_no_action_ocimem_a` with `autoinc`=1: clears `monitor_ready`, goes to RD at the current `MonAReg`. With `autoinc`=0 the strobe is ignored.
- Simultaneous strobes: ocimem_a beats ocimem_b, which beats no_action_ocimem_a. The losers are dropped.
- Strobes arriving in RD or WR are dropped with no state change; `monitor_error` is not set.
- RD: `avm_read`=1 is held while `avm_waitrequest`=1. In the cycle `avm_waitrequest`=0:
  - `MonDReg <= avm_readdata` and `monitor_ready <= 1`.
  - If `autoinc`, `MonAReg <= MonAReg+1`.
  - Next state is IDLE.
- WR: same as RD with `avm_write`=1. On acceptance `monitor_ready <= 1`, the address increments if `autoinc`, next state is IDLE.
- Timeout:
  - The counter clears on entry to RD/WR and increments every stalled cycle.
  - When it equals TIMEOUT_CYCLES while `avm_waitrequest`=1, the request drops, `monitor_error <= 1`, `monitor_ready <= 1` and the FSM returns to IDLE.
  - `MonDReg` and `MonAReg` stay unchanged.
- Address increments wrap 30'h3FFFFFFF -> 0.
- Reset values: state IDLE; `MonDReg`, `MonAReg`, `avm_writedata` 0; `avm_read`, `avm_write`, `autoinc`, `monitor_ready`, `monitor_error` 0; counter 0.
- Reset asserted mid-access drops the request on the next edge; no completion is reported.

## Timing
- Strobe at edge N: `avm_read`/`avm_write` is high from N+1 (registered output).
- Zero-wait slave: accepted at edge N+1; `MonDReg` and `monitor_ready` are valid after N+2; the FSM is IDLE at N+2.
- Each wait cycle adds one cycle of latency.
- With TIMEOUT_CYCLES=T and a permanently stalled slave:
  - The request is high for exactly T+1 cycles.
  - `monitor_error` rises together with the request falling.
- `avm_address` and `avm_writedata` are stable for the whole time the request is high.
- Maximum throughput: one access per 2 cycles.

## Structure
- Shared package `pd_block_debug_pkg`:
  - State enum `mem_bridge_state_t`.
  - jdo field constants `JDO_RD_BIT`=35, `JDO_AUTOINC_BIT`=34, `JDO_ADDR_MSB`=31, `JDO_ADDR_LSB`=2.
  - `MON_AW`=30.
- Single module, no sub-module; the timeout counter is inline.

## Test plan
- Read, zero-wait: `jdo[35]`=1, `jdo[31:0]`=0x0000_1000, `avm_readdata`=0xDEADBEEF.
  - -> `avm_address`=0x1000 for one cycle, `MonDReg`=0xDEADBEEF, `monitor_ready`=1, `monitor_error`=0.
- Write with 3 wait cycles: address 0x20 loaded with `jdo[35]`=0, then ocimem_b with `jdo[31:0]`=0x12345678.
  - -> `avm_write` high for 4 cycles at 0x20 with data 0x12345678, then `monitor_ready`=1.
- Streaming reads: autoinc=1 from 0x100, then 3 `take_no_action_ocimem_a` strobes.
  - -> addresses 0x100, 0x104, 0x108, 0x10C; `MonDReg` tracks each read.
- Timeout: TIMEOUT_CYCLES=7, `avm_waitrequest` stuck at 1.
  - -> `avm_read` high 8 cycles, then `monitor_error`=1, `monitor_ready`=1, `MonDReg` unchanged.
  - A following ocimem_a clears `monitor_error`.
- Wrap and collisions:
  - autoinc read at 0xFFFF_FFFC -> next address 0x0.
  - ocimem_a and ocimem_b in the same cycle -> read only.
  - A strobe during RD -> dropped.
  - `reset_n`=0 mid-RD -> `avm_read`=0 next cycle, all outputs at reset values.
